// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I(M) control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/MDWAIT/WB with memory and mul/div handshakes.
module multicycle_control_unit #(
   parameter bit          M_EXT      = 1'b1,
   parameter int unsigned MD_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Instr,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   input  logic        md_done,
   output logic        IRWr,
   output logic        PCWr,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        md_start,
   output logic        ALUASrc,
   output logic        ALUBSrc,
   output logic [3:0]  ALUOp,
   output logic [2:0]  ImmSrc,
   output logic        RUWr,
   output logic [4:0]  BrOp,
   output logic [2:0]  DMCtrl,
   output logic        DMWr,
   output logic [1:0]  RUDataWrSrc,
   output logic        illegal,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      MDWAIT = 3'd4,
      WB     = 3'd5,
      TRAP   = 3'd6
   } state_t;

   typedef struct packed {
      logic       asrc;
      logic       bsrc;
      logic [3:0] aluop;
      logic [2:0] imm;
      logic       ruwr;
      logic [4:0] brop;
      logic [2:0] dmctrl;
      logic       dmwr;
      logic [1:0] wrsrc;
      logic       mem;
      logic       md;
   } dec_t;

   localparam logic [7:0] MD_LAST = 8'(MD_TIMEOUT - 1);

   state_t     state_q, state_d;
   dec_t       dec_q, dec_d;
   logic       bad;
   logic [7:0] cnt_q, cnt_d;
   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       unused_instr;

   assign opc = Instr[6:0];
   assign f3  = Instr[14:12];
   assign f7  = Instr[31:25];
   assign unused_instr = ^{Instr[24:15], Instr[11:7]};
   assign state = state_q;

   always_comb begin
      dec_d = '0;
      bad   = 1'b0;
      case (opc)
         7'b0110011: begin
            dec_d.ruwr = 1'b1;
            if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
               dec_d.aluop = {f7[5], f3};
            end else if (M_EXT && f7 == 7'b0000001) begin
               // MUL runs in the ALU; the rest go to the iterative unit
               dec_d.aluop = (f3 == 3'b000) ? 4'b1110 : {1'b0, f3};
               dec_d.md    = (f3 != 3'b000);
               dec_d.wrsrc = (f3 != 3'b000) ? 2'b11 : 2'b00;
            end else begin
               bad = 1'b1;
            end
         end
         7'b0010011: begin
            dec_d.bsrc  = 1'b1;
            dec_d.ruwr  = 1'b1;
            dec_d.aluop = (f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
         end
         7'b0000011: begin
            dec_d.bsrc   = 1'b1;
            dec_d.ruwr   = 1'b1;
            dec_d.dmctrl = f3;
            dec_d.wrsrc  = 2'b01;
            dec_d.mem    = 1'b1;
         end
         7'b0100011: begin
            dec_d.bsrc   = 1'b1;
            dec_d.imm    = 3'b001;
            dec_d.dmctrl = f3;
            dec_d.dmwr   = 1'b1;
            dec_d.mem    = 1'b1;
         end
         7'b1100011: begin
            dec_d.asrc = 1'b1;
            dec_d.bsrc = 1'b1;
            dec_d.imm  = 3'b101;
            dec_d.brop = {2'b01, f3};
         end
         7'b1101111: begin
            dec_d.asrc  = 1'b1;
            dec_d.bsrc  = 1'b1;
            dec_d.imm   = 3'b110;
            dec_d.ruwr  = 1'b1;
            dec_d.brop  = 5'b10000;
            dec_d.wrsrc = 2'b10;
         end
         7'b1100111: begin
            dec_d.bsrc  = 1'b1;
            dec_d.ruwr  = 1'b1;
            dec_d.brop  = 5'b10000;
            dec_d.wrsrc = 2'b10;
         end
         7'b0110111: begin
            dec_d.bsrc  = 1'b1;
            dec_d.imm   = 3'b010;
            dec_d.aluop = 4'b1111;
            dec_d.ruwr  = 1'b1;
         end
         7'b0010111: begin
            dec_d.asrc  = 1'b1;
            dec_d.bsrc  = 1'b1;
            dec_d.imm   = 3'b010;
            dec_d.aluop = 4'b1111;
            dec_d.ruwr  = 1'b1;
         end
         default: bad = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         dec_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == DECODE && !bad) dec_q <= dec_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      IRWr        = 1'b0;
      PCWr        = 1'b0;
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      md_start    = 1'b0;
      ALUASrc     = 1'b0;
      ALUBSrc     = 1'b0;
      ALUOp       = '0;
      ImmSrc      = '0;
      RUWr        = 1'b0;
      BrOp        = '0;
      DMCtrl      = '0;
      DMWr        = 1'b0;
      RUDataWrSrc = '0;
      illegal     = 1'b0;
      // datapath selects only leave zero once the decode register is valid
      if (state_q inside {EXEC, MEM, MDWAIT, WB}) begin
         ALUASrc     = dec_q.asrc;
         ALUBSrc     = dec_q.bsrc;
         ALUOp       = dec_q.aluop;
         ImmSrc      = dec_q.imm;
         BrOp        = dec_q.brop;
         DMCtrl      = dec_q.dmctrl;
         RUDataWrSrc = dec_q.wrsrc;
      end
      case (state_q)
         FETCH: begin
            imem_req = 1'b1;
            IRWr     = imem_ready;
            if (imem_ready) state_d = DECODE;
         end
         DECODE: state_d = bad ? TRAP : EXEC;
         EXEC: begin
            md_start = dec_q.md;
            if (dec_q.mem) begin
               state_d = MEM;
            end else if (dec_q.md) begin
               cnt_d   = '0;
               state_d = MDWAIT;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            dmem_req = 1'b1;
            DMWr     = dec_q.dmwr;
            if (dmem_ready) state_d = WB;
         end
         MDWAIT: begin
            if (md_done) state_d = WB;
            else if (cnt_q == MD_LAST) state_d = TRAP;
            else cnt_d = cnt_q + 8'd1;
         end
         WB: begin
            PCWr    = 1'b1;
            RUWr    = dec_q.ruwr;
            state_d = FETCH;
         end
         TRAP: illegal = 1'b1;
         default: state_d = FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: decode table plus
// multi-cycle handshake, timeout, trap and reset-abort sequences.
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] Instr = '0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        md_done = 1'b0;

   logic       irwr [3];
   logic       pcwr [3];
   logic       ireq [3];
   logic       dreq [3];
   logic       mst  [3];
   logic       asrc [3];
   logic       bsrc [3];
   logic [3:0] aluop [3];
   logic [2:0] imms [3];
   logic       ruwr [3];
   logic [4:0] brop [3];
   logic [2:0] dmc  [3];
   logic       dmwr [3];
   logic [1:0] wsrc [3];
   logic       ill  [3];
   logic [2:0] stt  [3];

   always #5 clk = ~clk;

   // 0: M_EXT=1/timeout 64, 1: M_EXT=0, 2: M_EXT=1/timeout 8
   for (genvar g = 0; g < 3; g++) begin : g_dut
      multicycle_control_unit #(
         .M_EXT(g != 1),
         .MD_TIMEOUT((g == 2) ? 8 : 64)
      ) u_dut (
         .clk(clk), .rst(rst), .Instr(Instr),
         .imem_ready(imem_ready), .dmem_ready(dmem_ready),
         .md_done(md_done),
         .IRWr(irwr[g]), .PCWr(pcwr[g]), .imem_req(ireq[g]),
         .dmem_req(dreq[g]), .md_start(mst[g]),
         .ALUASrc(asrc[g]), .ALUBSrc(bsrc[g]), .ALUOp(aluop[g]),
         .ImmSrc(imms[g]), .RUWr(ruwr[g]), .BrOp(brop[g]),
         .DMCtrl(dmc[g]), .DMWr(dmwr[g]), .RUDataWrSrc(wsrc[g]),
         .illegal(ill[g]), .state(stt[g])
      );
   end

   int checks = 0;
   int errors = 0;

   logic [2:0] t_st [3][64];
   logic       t_il [3][64];
   logic       t_irwr [64], t_pcwr [64], t_ruwr [64];
   logic       t_dreq [64], t_dmwr [64], t_mst [64];
   logic       t_asrc [64], t_bsrc [64];
   logic [3:0] t_alu [64];
   logic [2:0] t_imm [64], t_dmc [64];
   logic [4:0] t_br [64];
   logic [1:0] t_ws [64];

   typedef struct {
      logic [31:0] ins;
      logic        mem;
      logic        asrc;
      logic        bsrc;
      logic [3:0]  alu;
      logic [2:0]  imm;
      logic [4:0]  br;
      logic [2:0]  dmc;
      logic [1:0]  ws;
      logic        ruwr;
      logic        dmwr;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      md_done = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // ilat/dlat/mlat: wait cycles before ready/done; mlat<0 = never
   task automatic run(input logic [31:0] ins, input int ilat,
                      input int dlat, input int mlat, input int ncyc,
                      input int sel);
      int w;
      logic [2:0] prev;
      logic [2:0] s;
      w = 0;
      prev = '0;
      Instr = ins;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk); #1;
         s = stt[sel];
         if (c == 0 || s != prev) w = 0;
         else w++;
         prev = s;
         imem_ready = (s == 3'd0) && (w >= ilat);
         dmem_ready = (s == 3'd3) && (w >= dlat);
         md_done = (s == 3'd4) && (mlat >= 0) && (w >= mlat);
         #3;
         for (int k = 0; k < 3; k++) begin
            t_st[k][c] = stt[k];
            t_il[k][c] = ill[k];
         end
         t_irwr[c] = irwr[sel];
         t_pcwr[c] = pcwr[sel];
         t_ruwr[c] = ruwr[sel];
         t_dreq[c] = dreq[sel];
         t_dmwr[c] = dmwr[sel];
         t_mst[c]  = mst[sel];
         t_asrc[c] = asrc[sel];
         t_bsrc[c] = bsrc[sel];
         t_alu[c]  = aluop[sel];
         t_imm[c]  = imms[sel];
         t_dmc[c]  = dmc[sel];
         t_br[c]   = brop[sel];
         t_ws[c]   = wsrc[sel];
      end
   endtask

   initial begin
      int n, wbc, pc_n, ru_n, ms_n, dr_n, md_n;

      tbl[0]  = '{32'h402081B3, 0, 0, 0, 4'b1000, 3'b000, 5'b00000, 3'b000, 2'b00, 1, 0};
      tbl[1]  = '{32'h4020D193, 0, 0, 1, 4'b1101, 3'b000, 5'b00000, 3'b000, 2'b00, 1, 0};
      tbl[2]  = '{32'hFFF0E193, 0, 0, 1, 4'b0110, 3'b000, 5'b00000, 3'b000, 2'b00, 1, 0};
      tbl[3]  = '{32'h0000A183, 1, 0, 1, 4'b0000, 3'b000, 5'b00000, 3'b010, 2'b01, 1, 0};
      tbl[4]  = '{32'h0030A023, 1, 0, 1, 4'b0000, 3'b001, 5'b00000, 3'b010, 2'b00, 0, 1};
      tbl[5]  = '{32'h0020D463, 0, 1, 1, 4'b0000, 3'b101, 5'b01101, 3'b000, 2'b00, 0, 0};
      tbl[6]  = '{32'h000000EF, 0, 1, 1, 4'b0000, 3'b110, 5'b10000, 3'b000, 2'b10, 1, 0};
      tbl[7]  = '{32'h000100E7, 0, 0, 1, 4'b0000, 3'b000, 5'b10000, 3'b000, 2'b10, 1, 0};
      tbl[8]  = '{32'h123451B7, 0, 0, 1, 4'b1111, 3'b010, 5'b00000, 3'b000, 2'b00, 1, 0};
      tbl[9]  = '{32'h00001197, 0, 1, 1, 4'b1111, 3'b010, 5'b00000, 3'b000, 2'b00, 1, 0};
      tbl[10] = '{32'h022081B3, 0, 0, 0, 4'b1110, 3'b000, 5'b00000, 3'b000, 2'b00, 1, 0};
      tbl[11] = '{32'h0020F1B3, 0, 0, 0, 4'b0111, 3'b000, 5'b00000, 3'b000, 2'b00, 1, 0};

      // reset state
      #4;
      chk("rst_state", stt[0], 0);
      chk("rst_imem_req", ireq[0], 1);
      chk("rst_others", {pcwr[0], ruwr[0], dreq[0], dmwr[0], mst[0],
                         irwr[0], ill[0], aluop[0], wsrc[0], brop[0]}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // reset mid-MEM on a store aborts it
      run(32'h0030A023, 0, 100, -1, 5, 0);
      chk("abort_in_mem", t_st[0][4], 3);
      chk("abort_dmwr_pre", t_dmwr[4], 1);
      @(posedge clk); #1;
      rst = 1'b1;
      #3;
      chk("abort_state", stt[0], 0);
      chk("abort_wr", {dmwr[0], pcwr[0], ruwr[0], dreq[0]}, 0);
      chk("abort_imem_req", ireq[0], 1);
      @(posedge clk); #1;
      rst = 1'b0;
      #3;
      chk("abort_next_wr", {dmwr[0], pcwr[0], ruwr[0]}, 0);
      chk("abort_next_state", stt[0], 0);

      // decode table, memories ready on first request
      foreach (tbl[i]) begin
         n = tbl[i].mem ? 5 : 4;
         run(tbl[i].ins, 0, 0, -1, n, 0);
         chk($sformatf("v%0d_fetch", i), {t_st[0][0], t_irwr[0]}, {3'd0, 1'b1});
         chk($sformatf("v%0d_decode", i), t_st[0][1], 1);
         chk($sformatf("v%0d_exec", i), t_st[0][2], 2);
         if (tbl[i].mem) begin
            chk($sformatf("v%0d_mem", i), t_st[0][3], 3);
            chk($sformatf("v%0d_dmwr", i), t_dmwr[3], tbl[i].dmwr);
            chk($sformatf("v%0d_dmc", i), t_dmc[3], tbl[i].dmc);
         end
         chk($sformatf("v%0d_wb", i), t_st[0][n-1], 5);
         chk($sformatf("v%0d_ctl", i),
             {t_asrc[2], t_bsrc[2], t_alu[2], t_imm[2], t_br[2]},
             {tbl[i].asrc, tbl[i].bsrc, tbl[i].alu, tbl[i].imm, tbl[i].br});
         chk($sformatf("v%0d_wbsig", i),
             {t_ws[n-1], t_ruwr[n-1], t_pcwr[n-1]},
             {tbl[i].ws, tbl[i].ruwr, 1'b1});
         pc_n = 0;
         ru_n = 0;
         ms_n = 0;
         for (int c = 0; c < n; c++) begin
            pc_n += int'(t_pcwr[c]);
            ru_n += int'(t_ruwr[c]);
            ms_n += int'(t_mst[c]);
         end
         chk($sformatf("v%0d_pulses", i), {pc_n[7:0], ru_n[7:0], ms_n[7:0]},
             {8'd1, 8'(tbl[i].ruwr), 8'd0});
      end

      // load with dmem_ready delayed 3 cycles
      do_reset();
      run(32'h0000A183, 0, 3, -1, 9, 0);
      dr_n = 0;
      wbc = -1;
      for (int c = 0; c < 9; c++) begin
         dr_n += int'(t_dreq[c]);
         if (wbc < 0 && t_st[0][c] == 3'd5) wbc = c + 1;
      end
      chk("lw_dreq_cycles", dr_n, 4);
      chk("lw_dreq_held", {t_dreq[3], t_dreq[6], t_dreq[7]}, 3'b110);
      chk("lw_dmctrl", t_dmc[5], 3'b010);
      chk("lw_wb_cycle", wbc, 8);
      chk("lw_wb_src", {t_ws[7], t_ruwr[7], t_pcwr[7]}, {2'b01, 1'b1, 1'b1});
      chk("lw_back_fetch", t_st[0][8], 0);

      // div, md_done after 10 wait cycles; M_EXT=0 copy traps
      do_reset();
      run(32'h0220C1B3, 0, 0, 10, 16, 0);
      ms_n = 0;
      md_n = 0;
      for (int c = 0; c < 16; c++) begin
         ms_n += int'(t_mst[c]);
         md_n += int'(t_st[0][c] == 3'd4);
      end
      chk("div_mdstart_exec", {t_st[0][2], t_mst[2]}, {3'd2, 1'b1});
      chk("div_mdstart_once", ms_n, 1);
      chk("div_mdwait_cycles", md_n, 11);
      chk("div_wb", {t_st[0][14], t_ws[14], t_ruwr[14], t_pcwr[14]},
          {3'd5, 2'b11, 1'b1, 1'b1});
      chk("div_mdwait_src", t_ws[8], 2'b11);
      chk("div_done_after_wb", t_st[0][15], 0);
      chk("nom_trap", {t_st[1][2], t_il[1][2]}, {3'd6, 1'b1});
      chk("nom_decode_clean", t_il[1][1], 0);
      chk("nom_trap_sticky", {t_st[1][15], t_il[1][15]}, {3'd6, 1'b1});

      // div timeout with MD_TIMEOUT=8
      do_reset();
      run(32'h0220C1B3, 0, 0, -1, 14, 2);
      md_n = 0;
      ru_n = 0;
      pc_n = 0;
      for (int c = 0; c < 14; c++) begin
         md_n += int'(t_st[2][c] == 3'd4);
         ru_n += int'(t_ruwr[c]);
         pc_n += int'(t_pcwr[c]);
      end
      chk("to_mdwait_cycles", md_n, 8);
      chk("to_last_wait", t_st[2][10], 4);
      chk("to_trap", {t_st[2][11], t_il[2][11]}, {3'd6, 1'b1});
      chk("to_no_writes", {ru_n[7:0], pc_n[7:0]}, 0);
      chk("to_not_illegal_early", t_il[2][10], 0);

      // all-ones instruction traps from DECODE
      do_reset();
      run(32'hFFFFFFFF, 0, 0, -1, 5, 0);
      chk("ill_decode", {t_st[0][1], t_il[0][1]}, {3'd1, 1'b0});
      chk("ill_trap", {t_st[0][2], t_il[0][2]}, {3'd6, 1'b1});
      chk("ill_stay", {t_st[0][4], t_pcwr[4], t_ruwr[4], t_irwr[4]},
          {3'd6, 3'b000});

      // R-type with unsupported funct7 traps
      do_reset();
      run(32'h042081B3, 0, 0, -1, 4, 0);
      chk("bad_f7_trap", {t_st[0][2], t_il[0][3]}, {3'd6, 1'b1});

      // md_done outside MDWAIT is ignored
      do_reset();
      Instr = 32'h402081B3;
      @(posedge clk); #1;
      imem_ready = 1'b1;
      md_done = 1'b1;
      #3;
      chk("md_done_fetch", stt[0], 0);
      @(posedge clk); #1;
      imem_ready = 1'b0;
      md_done = 1'b0;
      #3;
      chk("md_done_ignored", stt[0], 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle RV32I control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/MDWAIT/WB using ready handshakes to instruction memory, data memory and an iterative mul/div unit.
- Keeps the existing control-signal encodings. Adds optional M-extension dispatch, illegal-instruction detection and a mul/div timeout trap.
- Sits between the instruction register and the datapath muxes, ALU, register unit and data memory.

Parameters:
M_EXT, 1, 1 = accept funct7=0000001 R-type (M extension); 0 = treat it as illegal.
MD_TIMEOUT, 64, maximum cycles in MDWAIT before trapping; range 2..255.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
Instr  in  32  instruction register contents; valid from DECODE onward
imem_ready  in  1  instruction fetch complete
dmem_ready  in  1  data access complete
md_done  in  1  mul/div result valid (single-cycle pulse)
IRWr  out  1  load instruction register
PCWr  out  1  update PC
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
md_start  out  1  one-cycle mul/div start pulse
ALUASrc  out  1  0 = rs1, 1 = PC
ALUBSrc  out  1  0 = rs2, 1 = immediate
ALUOp  out  4  ALU operation
ImmSrc  out  3  immediate format
RUWr  out  1  register-file write enable
BrOp  out  5  branch operation
DMCtrl  out  3  data memory size/sign
DMWr  out  1  data memory write enable
RUDataWrSrc  out  2  00 = ALU, 01 = mem, 10 = PC+4, 11 = mul/div
illegal  out  1  sticky trap flag
state  out  3  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, MDWAIT=4, WB=5, TRAP=6.
- Decode register: the decoded controls are captured on the DECODE->EXEC edge and are stable through WB.
- All outputs are combinational functions of state and the decode register. No output carries x; don't-cares drive 0.
- Reset: state=FETCH, decode register cleared, MD counter=0, illegal=0.
  - Outputs during and after reset: imem_req=1, all others 0.
  - Reset asserted mid-instruction aborts it. There is no RUWr/DMWr/PCWr on the abort cycle or the following cycle.
- FETCH:
  - imem_req=1.
  - imem_ready=1: IRWr=1 that cycle, next state DECODE. Otherwise stay.
- DECODE: decode Instr, then go to EXEC, or to TRAP if illegal.
- Legal opcodes and encodings:
  - R (0110011): ALUOp={f7[5],f3}; MUL (f7=0000001, f3=000) gives ALUOp=1110.
  - I (0010011): ALUOp={f7[5],f3} when f3=101, else {0,f3}; ImmSrc=000.
  - Load (0000011): ALUOp=0000; DMCtrl=f3; RUDataWrSrc=01.
  - Store (0100011): ImmSrc=001; DMCtrl=f3; DMWr=1 in MEM only.
  - Branch (1100011): ALUASrc=1; ImmSrc=101; BrOp={01,f3}.
  - JAL (1101111): ImmSrc=110; BrOp=10000; RUDataWrSrc=10.
  - JALR (1100111): ImmSrc=000; BrOp=10000; RUDataWrSrc=10.
  - LUI (0110111): ImmSrc=010; ALUOp=1111.
  - AUIPC (0010111): ALUASrc=1; ImmSrc=010; ALUOp=1111.
  - Non-jump, non-branch instructions: BrOp=00000.
- Illegal instructions:
  - Any opcode not listed above.
  - R-type with f7 outside {0000000, 0100000}, or additionally 0000001 when M_EXT=1.
  - When M_EXT=0, f7=0000001 is illegal.
- EXEC transitions:
  - Load/store: go to MEM.
  - M op with f3≠000: md_start=1 for exactly this cycle, clear MD counter, go to MDWAIT.
  - Everything else: go to WB.
- MEM:
  - dmem_req=1, held until dmem_ready. DMWr=1 only for stores, held with dmem_req.
  - dmem_ready=1: go to WB.
- MDWAIT:
  - md_done=1: go to WB; RUDataWrSrc=11.
  - Otherwise the counter increments each cycle. When the counter reaches MD_TIMEOUT-1 without md_done, go to TRAP.
  - md_done and timeout in the same cycle: md_done wins.
  - md_done outside MDWAIT is ignored.
- WB (exactly one cycle):
  - PCWr=1.
  - RUWr=1 for all types except store and branch.
  - Next state FETCH.
- TRAP: illegal=1; all enables 0; remain until reset.
- Latency with memories ready on first request cycle:
  - ALU, branch, jump: 4 cycles.
  - Load, store: 5 cycles.
  - Mul/div: 5+N cycles, where N is the number of md_done wait cycles.

Test Plan:
- Reset asserted mid-MEM on a store (Instr 0x0030A023) -> next cycle state=0, DMWr=0, imem_req=1, no PCWr/RUWr pulse.
- Instr 0x402081B3 (sub), imem_ready tied 1 -> states 0,1,2,5; ALUOp=1000; RUWr=1 and PCWr=1 only in cycle 4.
- Instr 0x0000A183 (lw), dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, DMCtrl=010, RUDataWrSrc=01, WB on cycle 8.
- Instr 0x0220C1B3 (div), md_done after 10 cycles -> md_start single pulse in EXEC, WB with RUDataWrSrc=11. With M_EXT=0 -> TRAP, illegal=1.
- Same div with md_done never asserted, MD_TIMEOUT=8 -> TRAP after 8 MDWAIT cycles, RUWr never asserted.
- Instr 0x022081B3 (mul) -> ALUOp=1110, no md_start; Instr 0xFFFFFFFF -> TRAP from DECODE.
